// File: rtl/online_mult_seq.sv
// Sequencer for the radix-2 digit-serial online multiplier: clears the datapath,
// feeds operand digit pairs MSD first, then flushes DELTA zero digits under backpressure.
module online_mult_seq #(
  parameter int N     = 64,
  parameter int DELTA = 3,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] prec,
  input  logic          in_valid,
  output logic          in_req,
  input  logic          out_ready,
  output logic          dp_en,
  output logic          dp_clear,
  output logic          dp_zero_in,
  output logic [CW-1:0] dig_idx,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, CLEAR, INIT, COMPUTE, FLUSH, DONE} state_t;

  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state;
  logic [CW-1:0] p_reg;
  logic [CW-1:0] p_next;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          init_fire;
  logic          comp_fire;
  logic          flush_fire;

  // Precision below DELTA+1 would leave no compute phase, so it is raised to DELTA+1.
  always_comb begin
    p_next = prec;
    if (prec == '0 || prec > N_C)
      p_next = N_C;
    else if (prec <= DELTA_C)
      p_next = DELTA_C + ONE;
  end

  assign init_fire  = (state == INIT)    && in_valid && !abort;
  assign comp_fire  = (state == COMPUTE) && in_valid && out_ready && !abort;
  assign flush_fire = (state == FLUSH)   && out_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      p_reg   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (abort) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            p_reg <= p_next;
          end
        end
        CLEAR: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          state   <= INIT;
        end
        INIT: begin
          if (init_fire) begin
            in_cnt <= in_cnt + ONE;
            if (in_cnt == DELTA_C - ONE)
              state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (comp_fire) begin
            in_cnt  <= in_cnt + ONE;
            out_cnt <= out_cnt + ONE;
            if (in_cnt == p_reg - ONE)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_fire) begin
            out_cnt <= out_cnt + ONE;
            if (out_cnt == p_reg - ONE)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_req     = (state == INIT) || (state == COMPUTE);
  assign dp_en      = init_fire || comp_fire || flush_fire;
  assign dp_clear   = (state == CLEAR);
  assign dp_zero_in = (state == FLUSH);
  assign dig_idx    = in_req ? in_cnt : '0;
  assign out_valid  = comp_fire || flush_fire;
  assign out_last   = flush_fire && (out_cnt == p_reg - ONE);
  assign out_idx    = ((state == COMPUTE) || (state == FLUSH)) ? out_cnt : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !abort;

endmodule

// File: tb/tb_online_mult_seq.sv
// Bench for online_mult_seq: expected output digits are queued at start and
// popped as out_valid appears; phase timing and abort/reset behaviour checked per run.
module tb_online_mult_seq;
  localparam int N = 64;
  localparam int DELTA = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] prec = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_req, dp_en, dp_clear, dp_zero_in, out_valid, out_last, busy, done;
  logic [CW-1:0] dig_idx, out_idx;

  online_mult_seq #(.N(N), .DELTA(DELTA), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prec(prec),
    .in_valid(in_valid), .in_req(in_req), .out_ready(out_ready),
    .dp_en(dp_en), .dp_clear(dp_clear), .dp_zero_in(dp_zero_in), .dig_idx(dig_idx),
    .out_valid(out_valid), .out_last(out_last), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_miss = 0;
  logic [255:0] iv_low = '0;
  logic [255:0] or_low = '0;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int all_outs();
    return int'({in_req, dp_en, dp_clear, dp_zero_in, dig_idx, out_valid,
                 out_last, out_idx, busy, done});
  endfunction

  // kill_at < 0: normal run; kill_abort=1: abort in that cycle; else reset at its midpoint.
  task automatic run_op(input logic [CW-1:0] prec_v, input int p, input int exp_done,
                        input int exp_fo, input int exp_fz, input int kill_at,
                        input bit kill_abort);
    int   in_exp = 0, outs = 0, lasts = 0;
    int   clear_cyc = -1, fo = -1, fz = -1, done_cyc = -1;
    exp_t e;
    logic [7:0] ci;
    prec = prec_v;
    for (int k = 0; k < p; k++) begin
      e.idx = k; e.last = (k == p - 1); e.zero = (k >= p - DELTA);
      sb.push_back(e);
    end
    for (int c = 0; c < 250; c++) begin
      @(posedge clk); #1;
      ci = c[7:0];
      start     = (c == 0);
      in_valid  = !iv_low[ci];
      out_ready = !or_low[ci];
      abort     = kill_abort && (c == kill_at);
      @(negedge clk);
      if (kill_abort && c == kill_at + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_outs", all_outs(), 0);
        $display("op prec=%0d aborted at cycle %0d", prec_v, kill_at);
        sb.delete();
        return;
      end
      chk("busy", busy, (c > 0) ? 1 : 0);
      if (dp_clear && clear_cyc < 0) clear_cyc = c;
      if (in_req) chk("dig_idx", dig_idx, in_exp);
      if (in_req && !in_valid) chk("stall_in", dp_en, 0);
      if (dp_zero_in && !out_ready) chk("stall_flush", dp_en, 0);
      if (kill_abort && c == kill_at) begin
        chk("abort_dp_en", dp_en, 0);
        chk("abort_ov", out_valid, 0);
        chk("abort_done", done, 0);
      end else begin
        if (dp_en && in_req) in_exp++;
        if (out_valid) begin
          outs++;
          chk("ov_ready", out_ready, 1);
          chk("ov_dp_en", dp_en, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_idx", out_idx, e.idx);
            chk("out_last", out_last, e.last);
            chk("zero_in", dp_zero_in, e.zero);
            if (fo < 0) fo = c;
            if (e.zero && fz < 0) fz = c;
          end
        end else begin
          chk("last_wo_valid", out_last, 0);
        end
        if (out_last) lasts++;
      end
      if (!kill_abort && c == kill_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        $display("op prec=%0d reset at cycle %0d.5", prec_v, kill_at);
        sb.delete();
        return;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("clear_cyc", clear_cyc, 1);
    chk("inputs", in_exp, p);
    chk("outputs", outs, p);
    chk("last_count", lasts, 1);
    chk("sb_left", sb.size(), 0);
    if (exp_done >= 0) begin
      chk("done_cyc", done_cyc, exp_done);
      chk("first_out", fo, exp_fo);
      chk("first_flush", fz, exp_fz);
    end
    $display("op prec=%0d P=%0d: %0d in, %0d out, done at cycle %0d",
             prec_v, p, in_exp, outs, done_cyc);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);
    $display("reset state checked");

    // Plain P=8 run, no stalls.
    run_op(7'd8, 8, 13, 5, 10, -1, 1'b0);
    // in_valid low at cycles 3 and 6.
    iv_low = '0; iv_low[3] = 1'b1; iv_low[6] = 1'b1;
    run_op(7'd8, 8, 15, 7, 12, -1, 1'b0);
    iv_low = '0;
    // out_ready low at cycles 10-11 (flush).
    or_low[10] = 1'b1; or_low[11] = 1'b1;
    run_op(7'd8, 8, 15, 5, 12, -1, 1'b0);
    or_low = '0;
    // Precision boundaries.
    run_op(7'd0, 64, 69, 5, 66, -1, 1'b0);
    run_op(7'd2, 4, 9, 5, 6, -1, 1'b0);
    run_op(7'd3, 4, 9, 5, 6, -1, 1'b0);
    run_op(7'd100, 64, 69, 5, 66, -1, 1'b0);
    run_op(7'd64, 64, 69, 5, 66, -1, 1'b0);
    // Abort at cycle 7, then a fresh run.
    run_op(7'd8, 8, -1, -1, -1, 7, 1'b1);
    run_op(7'd8, 8, 13, 5, 10, -1, 1'b0);
    // Asynchronous reset at cycle 6.5, then a fresh run.
    run_op(7'd8, 8, -1, -1, -1, 6, 1'b0);
    run_op(7'd8, 8, 13, 5, 10, -1, 1'b0);
    // Random stalls on both handshakes.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        iv_low[i] = ($urandom_range(0, 3) == 0);
        or_low[i] = ($urandom_range(0, 3) == 0);
      end
      run_op(7'(5 + 3 * r), 5 + 3 * r, -1, -1, -1, -1, 1'b0);
    end
    iv_low = '0; or_low = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
